// File: rtl/upsampler_pkg.sv
// upsampler_pkg: shared state type, width helper and legal scale range for pixel_upsampler.
package upsampler_pkg;
    typedef enum logic [1:0] {FILL, PREFETCH, REPEAT} state_t;
    localparam int SCALE_LOG2_MAX = 2;
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/upsampler_line_ram.sv
// upsampler_line_ram: single-port line buffer, synchronous write and 1-cycle synchronous read.
module upsampler_line_ram
    import upsampler_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 400
) (
    input  logic                       clock,
    input  logic                       we,
    input  logic                       re,
    input  logic [width_of(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clock) begin
        if (we) mem[addr] <= wdata;
        else if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/pixel_upsampler.sv
// pixel_upsampler: nearest-neighbour 2^SCALE_LOG2 upsampler replaying rows from a line RAM.
// Define UPSAMPLE_COORD_EN to add the out_row/out_col coordinate outputs.
module pixel_upsampler
    import upsampler_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int IN_W       = 400,
    parameter int IN_H       = 300,
    parameter int SCALE_LOG2 = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_sof,
`ifdef UPSAMPLE_COORD_EN
    output logic [width_of(IN_H << SCALE_LOG2)-1:0] out_row,
    output logic [width_of(IN_W << SCALE_LOG2)-1:0] out_col,
`endif
    output logic              out_eol
);
    localparam int S  = 1 << SCALE_LOG2;
    localparam int HW = width_of(S);
    localparam int CW = width_of(IN_W);
    localparam int RW = width_of(IN_H);

    if (SCALE_LOG2 < 0 || SCALE_LOG2 > SCALE_LOG2_MAX) begin : g_bad_scale
        $error("pixel_upsampler: SCALE_LOG2 outside 0..2");
    end

    state_t state, state_nx;
    logic [HW-1:0] hrep, vrep;
    logic [CW-1:0] icol, wr_col, ram_addr;
    logic [RW-1:0] irow;
    logic [DATA_W-1:0] data_reg, ram_rdata;
    logic vld_reg, in_fire, out_fire, h_last, v_last, c_last, r_last, ram_we, ram_re;

    assign h_last   = hrep == HW'(S - 1);
    assign v_last   = vrep == HW'(S - 1);
    assign c_last   = icol == CW'(IN_W - 1);
    assign r_last   = irow == RW'(IN_H - 1);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    // A pixel accepted alongside the last replica belongs to the next column.
    assign wr_col   = vld_reg ? (c_last ? '0 : icol + 1'b1) : icol;

    always_ff @(posedge clock) state <= reset ? FILL : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            FILL:     if (out_fire && h_last && c_last && S > 1) state_nx = PREFETCH;
            PREFETCH: state_nx = REPEAT;
            REPEAT:   if (out_fire && h_last && c_last) state_nx = v_last ? FILL : PREFETCH;
            default:  state_nx = FILL;
        endcase
    end

    // The last column of a row to be repeated must not pull in the next row's first pixel.
    always_comb begin
        out_valid = (state == REPEAT) || (state == FILL && vld_reg);
        in_ready  = !reset && state == FILL && (!vld_reg || (out_ready && h_last && (S == 1 || !c_last)));
        out_data  = (state == REPEAT) ? ram_rdata : data_reg;
        out_sof   = out_valid && irow == '0 && vrep == '0 && icol == '0 && hrep == '0;
        out_eol   = out_valid && c_last && h_last;
        ram_we    = state == FILL && in_fire;
        ram_re    = state == PREFETCH || (state == REPEAT && out_fire && h_last && !c_last);
        ram_addr  = (state == FILL) ? wr_col : (state == PREFETCH) ? '0 : icol + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hrep     <= '0;
            vrep     <= '0;
            icol     <= '0;
            irow     <= '0;
            vld_reg  <= 1'b0;
            data_reg <= '0;
        end else begin
            if (out_fire) begin
                hrep <= h_last ? '0 : hrep + 1'b1;
                if (h_last) begin
                    icol <= c_last ? '0 : icol + 1'b1;
                    if (c_last) begin
                        vrep <= v_last ? '0 : vrep + 1'b1;
                        if (v_last) irow <= r_last ? '0 : irow + 1'b1;
                    end
                end
            end
            if (in_fire) begin
                data_reg <= in_data;
                vld_reg  <= 1'b1;
            end else if (out_fire && h_last) begin
                vld_reg <= 1'b0;
            end
        end
    end

`ifdef UPSAMPLE_COORD_EN
    always_comb begin
        out_row = $bits(out_row)'(int'(irow) * S + int'(vrep));
        out_col = $bits(out_col)'(int'(icol) * S + int'(hrep));
    end
`endif

    upsampler_line_ram #(.DATA_W(DATA_W), .DEPTH(IN_W)) u_ram (
        .clock(clock),
        .we(ram_we),
        .re(ram_re),
        .addr(ram_addr),
        .wdata(in_data),
        .rdata(ram_rdata)
    );
endmodule

// File: tb/tb_pixel_upsampler.sv
// tb_pixel_upsampler: three configurations (2x, passthrough, 4x) checked against a raster-level model.
module tb_pixel_upsampler;
    localparam int NC = 3;
    localparam int IWS [NC] = '{4, 4, 2};
    localparam int IHS [NC] = '{2, 2, 1};
    localparam int SLS [NC] = '{1, 0, 2};

    typedef struct { int din; int dout; } vec_t;
    typedef struct { int k; int frames; int first; int gap; int rdy; int stop; bit tbl; } scen_t;
    typedef struct { logic [7:0] data; bit sof; bit eol; int row; int col; } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic       in_valid  [NC];
    logic [7:0] in_data   [NC];
    logic       in_ready  [NC];
    logic       out_valid [NC];
    logic [7:0] out_data  [NC];
    logic       out_ready [NC];
    logic       out_sof   [NC];
    logic       out_eol   [NC];
`ifdef UPSAMPLE_COORD_EN
    logic [15:0] out_row [NC];
    logic [15:0] out_col [NC];
`endif
    int n_cmp = 0;
    int n_bad = 0;
    vec_t  vt [32];
    scen_t sc [9];

    always #5 clock = ~clock;

    for (genvar g = 0; g < NC; g++) begin : g_dut
`ifdef UPSAMPLE_COORD_EN
        logic [upsampler_pkg::width_of(IHS[g] << SLS[g])-1:0] r;
        logic [upsampler_pkg::width_of(IWS[g] << SLS[g])-1:0] c;
        assign out_row[g] = 16'(r);
        assign out_col[g] = 16'(c);
`endif
        pixel_upsampler #(.DATA_W(8), .IN_W(IWS[g]), .IN_H(IHS[g]), .SCALE_LOG2(SLS[g])) u_dut (
            .clock(clock),
            .reset(reset),
            .in_valid(in_valid[g]),
            .in_data(in_data[g]),
            .in_ready(in_ready[g]),
            .out_valid(out_valid[g]),
            .out_data(out_data[g]),
            .out_ready(out_ready[g]),
            .out_sof(out_sof[g]),
`ifdef UPSAMPLE_COORD_EN
            .out_row(r),
            .out_col(c),
`endif
            .out_eol(out_eol[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic do_reset(input int k);
        for (int j = 0; j < NC; j++) begin
            in_valid[j]  = 1'b0;
            in_data[j]   = 8'h00;
            out_ready[j] = 1'b0;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("reset in_ready", in_ready[k], 0);
        @(posedge clock);
        #1;
        chk("reset out_valid", out_valid[k], 0);
        chk("reset out_data", out_data[k], 0);
        chk("reset out_sof", out_sof[k], 0);
        chk("reset out_eol", out_eol[k], 0);
`ifdef UPSAMPLE_COORD_EN
        chk("reset out_row", out_row[k], 0);
        chk("reset out_col", out_col[k], 0);
`endif
        reset = 1'b0;
        #1;
        chk("in_ready after reset", in_ready[k], 1);
    endtask

    task automatic run_stream(input scen_t c);
        int k, s, iw, ih, ow, oh, n_in, n_out, ii, oi, t_in, t_prev, budget;
        bit pend, was_stall, full;
        logic [7:0] held;
        logic [7:0] pix [$];
        exp_t q [$];
        exp_t e;
        k = c.k;
        s = 1 << SLS[k];
        iw = IWS[k];
        ih = IHS[k];
        ow = iw * s;
        oh = ih * s;
        n_in = c.frames * iw * ih;
        for (int i = 0; i < n_in; i++)
            pix.push_back(c.tbl ? 8'(vt[i].din) : (c.first > 0) ? 8'(c.first + i) : 8'($urandom));
        // Every output pixel (x, y) is input pixel (x/s, y/s) of the same frame.
        for (int f = 0; f < c.frames; f++)
            for (int y = 0; y < oh; y++)
                for (int x = 0; x < ow; x++) begin
                    e.data = pix[f * iw * ih + (y / s) * iw + x / s];
                    e.sof = (x == 0 && y == 0);
                    e.eol = (x == ow - 1);
                    e.row = y;
                    e.col = x;
                    q.push_back(e);
                end
        if (c.tbl) for (int i = 0; i < 32; i++) q[i].data = 8'(vt[i].dout);
        n_out = (c.stop > 0) ? c.stop : q.size();
        full = (c.gap == 1 && c.rdy == 100);
        budget = 10 * n_out + 50;
        ii = 0;
        oi = 0;
        t_in = 0;
        t_prev = 0;
        pend = 1'b0;
        was_stall = 1'b0;
        held = 8'h00;
        for (int cyc = 0; cyc < budget && oi < n_out; cyc++) begin
            if (!pend && ii < n_in && cyc % c.gap == 0) pend = 1'b1;
            in_valid[k] = pend;
            if (pend) in_data[k] = pix[ii];
            out_ready[k] = ($urandom_range(99) < c.rdy);
            #1;
            if (was_stall) begin
                chk("stall out_valid held", out_valid[k], 1);
                chk("stall out_data held", out_data[k], held);
            end
            if (in_valid[k] && in_ready[k]) begin
                if (ii == 0) t_in = cyc;
                ii++;
                pend = 1'b0;
            end
            if (out_valid[k] && in_ready[k])
                chk("in_ready only on last replica", out_ready[k] && (q[oi].col % s == s - 1), 1);
            if (out_valid[k] && out_ready[k]) begin
                e = q[oi];
                chk("out_data", out_data[k], e.data);
                chk("out_sof", out_sof[k], e.sof);
                chk("out_eol", out_eol[k], e.eol);
`ifdef UPSAMPLE_COORD_EN
                chk("out_row", out_row[k], e.row);
                chk("out_col", out_col[k], e.col);
`endif
                if (full && oi == 0) chk("first output latency", cyc - t_in, 1);
                if (full && oi > 0) chk("output spacing", cyc - t_prev, (s > 1 && oi % ow == 0) ? 2 : 1);
                t_prev = cyc;
                oi++;
            end
            was_stall = out_valid[k] && !out_ready[k];
            held = out_data[k];
            @(posedge clock);
            #1;
        end
        chk("transfers completed", oi, n_out);
        if (c.stop == 0) chk("inputs consumed", ii, n_in);
    endtask

    initial begin
        vt = '{'{1, 1}, '{2, 1}, '{3, 2}, '{4, 2}, '{5, 3}, '{6, 3}, '{7, 4}, '{8, 4},
               '{0, 1}, '{0, 1}, '{0, 2}, '{0, 2}, '{0, 3}, '{0, 3}, '{0, 4}, '{0, 4},
               '{0, 5}, '{0, 5}, '{0, 6}, '{0, 6}, '{0, 7}, '{0, 7}, '{0, 8}, '{0, 8},
               '{0, 5}, '{0, 5}, '{0, 6}, '{0, 6}, '{0, 7}, '{0, 7}, '{0, 8}, '{0, 8}};
        sc = '{'{0, 1, 1, 1, 100, 0, 1'b1},
               '{0, 1, 1, 1, 50, 0, 1'b1},
               '{0, 3, 0, 1, 60, 0, 1'b0},
               '{1, 1, 1, 1, 100, 0, 1'b0},
               '{1, 2, 0, 2, 70, 0, 1'b0},
               '{0, 1, 1, 1, 50, 12, 1'b0},
               '{0, 1, 10, 1, 100, 0, 1'b0},
               '{2, 2, 1, 3, 100, 0, 1'b0},
               '{2, 2, 0, 3, 50, 0, 1'b0}};
        // Scenario 5 stops inside the first repeated row; the next reset lands mid-REPEAT.
        for (int i = 0; i < 9; i++) begin
            do_reset(sc[i].k);
            run_stream(sc[i]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
